// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared types for the data memory responder.
//   mem_access_size_t  request access size (BYTE/HALF/WORD, 2'b11 is illegal)
//   mem_rsp_state_t    responder FSM states
//   MEM_RSP_LATENCY_W  width of the wait-cycle counter
package data_mem_responder_pkg;
   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_access_size_t;
   typedef enum logic [1:0] {
      RSP_IDLE = 2'b00,
      RSP_WAIT = 2'b01,
      RSP_RESP = 2'b10
   } mem_rsp_state_t;
   localparam int MEM_RSP_LATENCY_W = 4;
endpackage

// File: rtl/data_mem_responder_lane.sv
// mem_byte_lane: combinational byte-lane steering for one RAM word.
//   addr_i     byte offset within the word
//   size_i     access size
//   wdata_i    right-aligned write data
//   word_i     current RAM word
//   be_o       byte enables for a write
//   wdata_o    write data replicated across lanes
//   rdata_o    selected lanes shifted to bit 0, zero-extended
//   misalign_o access not naturally aligned for its size
module mem_byte_lane
   import data_mem_responder_pkg::*;
(
   input  logic [1:0]  addr_i,
   input  logic [1:0]  size_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] word_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o
);
   logic is_b, is_h, is_w;
   logic [31:0] shifted;
   assign is_b = size_i == MEM_BYTE;
   assign is_h = size_i == MEM_HALF;
   assign is_w = size_i == MEM_WORD;
   // For a legal half access addr_i[0]=0, so shifting by the full offset equals {addr[1],0}.
   assign shifted    = word_i >> {addr_i, 3'b000};
   assign be_o       = is_b ? 4'b0001 << addr_i :
                       is_h ? 4'b0011 << {addr_i[1], 1'b0} :
                       is_w ? 4'b1111 : 4'b0000;
   assign wdata_o    = is_b ? {4{wdata_i[7:0]}} : is_h ? {2{wdata_i[15:0]}} : wdata_i;
   assign rdata_o    = is_b ? {24'b0, shifted[7:0]} : is_h ? {16'b0, shifted[15:0]} : shifted;
   assign misalign_o = (is_h & addr_i[0]) | (is_w & |addr_i);
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised RAM responder with configurable wait and sticky error.
//   clk_i, reset_ni                  clock, asynchronous active-low reset
//   req_valid_i/req_ready_o          request handshake (ready only in IDLE)
//   req_we_i, req_addr_i, req_size_i, req_wdata_i  request fields
//   rsp_valid_o/rsp_ready_i          response handshake
//   rsp_rdata_o, rsp_error_o         response payload
//   error_o                          sticky error, cleared only by reset
//   rd_count_o, wr_count_o           good read/write response counters, present only
//                                    when MEM_RSP_ACCESS_COUNTERS_EN is defined
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [1:0]  req_size_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_error_o,
   output logic        error_o
`ifdef MEM_RSP_ACCESS_COUNTERS_EN
   ,
   output logic [31:0] rd_count_o,
   output logic [31:0] wr_count_o
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [MEM_RSP_LATENCY_W-1:0] LAT = MEM_RSP_LATENCY_W'(LATENCY);
   logic [31:0] mem_q [DEPTH];
   mem_rsp_state_t state_q, state_d;
   logic [MEM_RSP_LATENCY_W-1:0] cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic err_q, err_d, we_q, we_d, error_q, error_d;
   logic [AW-1:0] idx;
   logic [3:0] be;
   logic [31:0] lane_wdata, lane_rdata;
   logic misalign, bad, accept, hs;
   assign idx = req_addr_i[AW+1:2];
   mem_byte_lane u_lane (
      .addr_i    (req_addr_i[1:0]),
      .size_i    (req_size_i),
      .wdata_i   (req_wdata_i),
      .word_i    (mem_q[idx]),
      .be_o      (be),
      .wdata_o   (lane_wdata),
      .rdata_o   (lane_rdata),
      .misalign_o(misalign)
   );
   assign bad    = misalign | (req_size_i == 2'b11) | (req_addr_i >= 32'(DEPTH) * 32'd4);
   assign accept = req_valid_i & (state_q == RSP_IDLE);
   assign hs     = (state_q == RSP_RESP) & rsp_ready_i;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      we_d    = we_q;
      error_d = error_q;
      if (accept) begin
         state_d = RSP_WAIT;
         cnt_d   = '0;
         rdata_d = (bad | req_we_i) ? 32'b0 : lane_rdata;
         err_d   = bad;
         we_d    = req_we_i;
      end
      if (state_q == RSP_WAIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAT) begin
            state_d = RSP_RESP;
            cnt_d   = '0;
            error_d = error_q | err_q;
         end
      end
      if (hs) state_d = RSP_IDLE;
   end
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= RSP_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         we_q    <= we_d;
         error_q <= error_d;
      end
   end
   // RAM is deliberately not reset so committed writes survive a reset.
   always_ff @(posedge clk_i) begin
      if (accept & req_we_i & ~bad)
         for (int b = 0; b < 4; b++)
            if (be[b]) mem_q[idx][b*8 +: 8] <= lane_wdata[b*8 +: 8];
   end
   assign req_ready_o = state_q == RSP_IDLE;
   assign rsp_valid_o = state_q == RSP_RESP;
   assign rsp_rdata_o = rsp_valid_o ? rdata_q : 32'b0;
   assign rsp_error_o = rsp_valid_o & err_q;
   assign error_o     = error_q;
`ifdef MEM_RSP_ACCESS_COUNTERS_EN
   logic [31:0] rd_cnt_q, wr_cnt_q;
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else if (hs & ~err_q) begin
         if (we_q) wr_cnt_q <= wr_cnt_q + 32'd1;
         else      rd_cnt_q <= rd_cnt_q + 32'd1;
      end
   end
   assign rd_count_o = rd_cnt_q;
   assign wr_count_o = wr_cnt_q;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: self-checking bench for data_mem_responder (DEPTH=16, LATENCY=1).
module tb_data_mem_responder;
   localparam int DEPTH = 16;
   localparam int LAT   = 1;
   logic        clk_i = 1'b0, reset_ni = 1'b0;
   logic        req_valid_i = 1'b0, req_we_i = 1'b0, rsp_ready_i = 1'b0;
   logic [31:0] req_addr_i = '0, req_wdata_i = '0;
   logic [1:0]  req_size_i = '0;
   logic        req_ready_o, rsp_valid_o, rsp_error_o, error_o;
   logic [31:0] rsp_rdata_o;
`ifdef MEM_RSP_ACCESS_COUNTERS_EN
   logic [31:0] rd_count_o, wr_count_o;
`endif
   data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .rsp_error_o(rsp_error_o), .error_o(error_o)
`ifdef MEM_RSP_ACCESS_COUNTERS_EN
      , .rd_count_o(rd_count_o), .wr_count_o(wr_count_o)
`endif
   );
   always #5 clk_i = ~clk_i;

   int passed = 0, total = 0;
   logic [7:0] mbytes [DEPTH*4];
   bit sticky = 0;
   int rd_exp = 0, wr_exp = 0;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [1:0]  sz;
      logic [31:0] wd;
      logic [31:0] rd;
      bit          err;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   // Byte-addressed reference memory: an access touches 2**size consecutive bytes.
   function automatic void model(input bit we, input logic [31:0] a, input logic [1:0] sz,
                                 input logic [31:0] wd, output logic [31:0] rd, output bit err);
      int n = 1 << sz;
      err = (sz == 2'd3) || (a % n != 0) || (a >= DEPTH * 4);
      rd = '0;
      if (!err)
         for (int k = 0; k < n; k++)
            if (we) mbytes[a+k] = wd[8*k +: 8];
            else    rd[8*k +: 8] = mbytes[a+k];
   endfunction

   task automatic xact(input bit we, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                       input int hold, output logic [31:0] rd, output logic er, output logic st,
                       output int lat);
      @(negedge clk_i);
      check("req_ready_idle", 32'(req_ready_o), 1);
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_size_i = sz; req_wdata_i = wd;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      lat = 0;
      while (!rsp_valid_o && lat < 50) begin
         @(posedge clk_i); #1;
         lat++;
      end
      rd = rsp_rdata_o; er = rsp_error_o; st = error_o;
      if (hold > 0) begin
         // A stray write offered during RESP must be ignored.
         req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h0; req_size_i = 2'd2;
         req_wdata_i = 32'hFFFF_FFFF;
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk_i); #1;
         check("hold_valid", 32'(rsp_valid_o), 1);
         check("hold_rdata", rsp_rdata_o, rd);
         check("hold_error", 32'(rsp_error_o), 32'(er));
         check("hold_ready", 32'(req_ready_o), 0);
      end
      @(negedge clk_i);
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b0;
      check("rsp_drop", 32'(rsp_valid_o), 0);
   endtask

   task automatic run(input bit we, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                      input int hold, input logic [31:0] erd, input bit eerr);
      logic [31:0] rd;
      logic er, st;
      int lat;
      xact(we, a, sz, wd, hold, rd, er, st, lat);
      if (eerr) sticky = 1;
      else if (we) wr_exp++;
      else rd_exp++;
      check("rdata", rd, erd);
      check("rsp_error", 32'(er), 32'(eerr));
      check("latency", lat, LAT + 1);
      check("error_o", 32'(st), 32'(sticky));
   endtask

   task automatic counters(input string tag);
`ifdef MEM_RSP_ACCESS_COUNTERS_EN
      check({tag, "_rd_count"}, rd_count_o, rd_exp);
      check({tag, "_wr_count"}, wr_count_o, wr_exp);
`else
      check({tag, "_idle_ready"}, 32'(req_ready_o), 1);
`endif
   endtask

   task automatic rand_xact();
      bit we;
      logic [1:0] sz;
      logic [31:0] a, wd, erd;
      bit eerr;
      int n;
      we = 1'($urandom);
      sz = 2'($urandom);
      n  = 1 << sz;
      a  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 'h4F))
                                       : 32'($urandom_range(0, DEPTH*4-1) / n * n);
      wd = $urandom;
      model(we, a, sz, wd, erd, eerr);
      run(we, a, sz, wd, $urandom_range(0, 2), erd, eerr);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] d, erd;
      bit e;
      int hi[$];
      int nhi;
      tbl.push_back('{1'b1, 32'h10, 2'd2, 32'hDEADBEEF, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h10, 2'd2, 32'h0,        32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b0, 32'h13, 2'd0, 32'h0,        32'h000000DE, 1'b0});
      tbl.push_back('{1'b0, 32'h12, 2'd1, 32'h0,        32'h0000DEAD, 1'b0});
      tbl.push_back('{1'b1, 32'h20, 2'd2, 32'h0,        32'h0,        1'b0});
      tbl.push_back('{1'b1, 32'h21, 2'd0, 32'h5A,       32'h0,        1'b0});
      tbl.push_back('{1'b1, 32'h22, 2'd1, 32'h1234,     32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h20, 2'd2, 32'h0,        32'h12345A00, 1'b0});
      tbl.push_back('{1'b1, 32'h04, 2'd2, 32'hCAFEF00D, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h06, 2'd2, 32'h0,        32'h0,        1'b1});
      tbl.push_back('{1'b1, 32'h05, 2'd1, 32'hBEEF,     32'h0,        1'b1});
      tbl.push_back('{1'b0, 32'h04, 2'd2, 32'h0,        32'hCAFEF00D, 1'b0});
      tbl.push_back('{1'b1, 32'h3C, 2'd2, 32'h11223344, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 32'h40, 2'd2, 32'h55,       32'h0,        1'b1});
      tbl.push_back('{1'b0, 32'h3C, 2'd2, 32'h0,        32'h11223344, 1'b0});
      tbl.push_back('{1'b0, 32'h00, 2'd3, 32'h0,        32'h0,        1'b1});
      tbl.push_back('{1'b0, 32'h41, 2'd0, 32'h0,        32'h0,        1'b1});

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_req_ready", 32'(req_ready_o), 1);
      check("rst_rsp_valid", 32'(rsp_valid_o), 0);
      check("rst_rsp_rdata", rsp_rdata_o, 0);
      check("rst_rsp_error", 32'(rsp_error_o), 0);
      check("rst_error_o", 32'(error_o), 0);
      counters("rst");
      @(negedge clk_i);
      reset_ni = 1'b1;

      // Fill every word so the reference model is fully defined
      for (int i = 0; i < DEPTH; i++) begin
         d = $urandom;
         model(1'b1, 32'(i*4), 2'd2, d, erd, e);
         run(1'b1, 32'(i*4), 2'd2, d, 0, 32'h0, 1'b0);
      end

      // Directed vectors
      foreach (tbl[i]) begin
         model(tbl[i].we, tbl[i].addr, tbl[i].sz, tbl[i].wd, erd, e);
         run(tbl[i].we, tbl[i].addr, tbl[i].sz, tbl[i].wd, (i == 1) ? 5 : 0, tbl[i].rd, tbl[i].err);
      end
      counters("table");

      // Throughput: requests and response-ready held high, one response per LATENCY+3 cycles
      @(negedge clk_i);
      rsp_ready_i = 1'b1;
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h10; req_size_i = 2'd2;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk_i); #1;
         if (rsp_valid_o) begin
            hi.push_back(c);
            check("tput_rdata", rsp_rdata_o, 32'hDEADBEEF);
         end
      end
      @(negedge clk_i);
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b0;
      nhi = hi.size();
      check("tput_pulses", nhi, 3);
      check("tput_first", (nhi > 0) ? hi[0] : -1, LAT + 1);
      check("tput_spacing", (nhi > 1) ? hi[1] - hi[0] : -1, LAT + 3);
      rd_exp += nhi;
      counters("tput");

      // Reset mid-WAIT: outputs return asynchronously, the accepted write stays committed
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h30; req_size_i = 2'd2;
      req_wdata_i = 32'h0BADC0DE;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      @(posedge clk_i); #2;
      check("mid_wait_valid", 32'(rsp_valid_o), 0);
      check("mid_wait_ready", 32'(req_ready_o), 0);
      check("sticky_before_reset", 32'(error_o), 1);
      reset_ni = 1'b0;
      #1;
      check("arst_req_ready", 32'(req_ready_o), 1);
      check("arst_rsp_valid", 32'(rsp_valid_o), 0);
      check("arst_rsp_rdata", rsp_rdata_o, 0);
      check("arst_rsp_error", 32'(rsp_error_o), 0);
      check("arst_error_o", 32'(error_o), 0);
      model(1'b1, 32'h30, 2'd2, 32'h0BADC0DE, erd, e);
      sticky = 0; rd_exp = 0; wr_exp = 0;
      counters("arst");
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      reset_ni = 1'b1;
      run(1'b0, 32'h30, 2'd2, 32'h0, 0, 32'h0BADC0DE, 1'b0);

      // Counter scenario: 3 good reads (one above), 2 good writes, 1 error
      run(1'b0, 32'h10, 2'd0, 32'h0, 1, 32'h000000EF, 1'b0);
      run(1'b0, 32'h20, 2'd1, 32'h0, 0, 32'h00005A00, 1'b0);
      model(1'b1, 32'h08, 2'd2, 32'h76543210, erd, e);
      run(1'b1, 32'h08, 2'd2, 32'h76543210, 0, 32'h0, 1'b0);
      model(1'b1, 32'h09, 2'd0, 32'hAB, erd, e);
      run(1'b1, 32'h09, 2'd0, 32'hAB, 0, 32'h0, 1'b0);
      run(1'b0, 32'h0A, 2'd2, 32'h0, 0, 32'h0, 1'b1);
      counters("cnt");
      run(1'b0, 32'h08, 2'd2, 32'h0, 0, 32'h7654AB10, 1'b0);

      // Randomized traffic against the byte-array model
      for (int i = 0; i < 60; i++) rand_xact();
      counters("final");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
